// File: rtl/core_cmd_scheduler.sv
// Request FIFO and single-outstanding issue scheduler for the Division/Root core.
// Optional SCHED_STATS_EN adds saturating done/timeout response counters.
module core_cmd_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [9:0]  req_data_1,
    input  logic [2:0]  req_data_2,
    output logic        core_in_valid,
    output logic        core_in_mode,
    output logic [9:0]  core_in_data_1,
    output logic [2:0]  core_in_data_2,
    input  logic        core_out_valid,
    input  logic [19:0] core_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_mode,
    output logic [19:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0] stat_done,
    output logic [7:0]  stat_tmo
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [13:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    cnt;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    // Storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_mode, req_data_1, req_data_2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            cnt            <= '0;
            core_in_valid  <= 1'b0;
            core_in_mode   <= 1'b0;
            core_in_data_1 <= '0;
            core_in_data_2 <= '0;
            rsp_valid      <= 1'b0;
            rsp_mode       <= 1'b0;
            rsp_data       <= '0;
            rsp_timeout    <= 1'b0;
`ifdef SCHED_STATS_EN
            stat_done      <= '0;
            stat_tmo       <= '0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        {core_in_mode, core_in_data_1, core_in_data_2} <= mem[rd_ptr];
                        core_in_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_in_valid <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (core_out_valid) begin
                        rsp_data    <= core_out_data;
                        rsp_mode    <= core_in_mode;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == 8'(TIMEOUT)) begin
                        rsp_data    <= '0;
                        rsp_mode    <= core_in_mode;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
`ifdef SCHED_STATS_EN
                        if (rsp_timeout) begin
                            if (stat_tmo != '1) stat_tmo <= stat_tmo + 1'b1;
                        end else begin
                            if (stat_done != '1) stat_done <= stat_done + 1'b1;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_cmd_scheduler.sv
// Bench for core_cmd_scheduler: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_core_cmd_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_mode = 1'b0;
    logic [9:0]  req_data_1 = '0;
    logic [2:0]  req_data_2 = '0;
    logic        core_in_valid;
    logic        core_in_mode;
    logic [9:0]  core_in_data_1;
    logic [2:0]  core_in_data_2;
    logic        core_out_valid = 1'b0;
    logic [19:0] core_out_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_mode;
    logic [19:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
`ifdef SCHED_STATS_EN
    logic [15:0] stat_done;
    logic [7:0]  stat_tmo;
`endif

    core_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_data_1(req_data_1), .req_data_2(req_data_2),
        .core_in_valid(core_in_valid), .core_in_mode(core_in_mode),
        .core_in_data_1(core_in_data_1), .core_in_data_2(core_in_data_2),
        .core_out_valid(core_out_valid), .core_out_data(core_out_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mode(rsp_mode),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
`ifdef SCHED_STATS_EN
        , .stat_done(stat_done), .stat_tmo(stat_tmo)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: pending queue plus the one outstanding operation.
    logic [13:0] m_q[$];
    int          m_phase = 0;   // 0 idle, 1 just issued, 2 waiting, 3 answering
    int          m_cnt = 0;
    logic        m_civ = 0, m_mode = 0, m_rv = 0, m_rmode = 0, m_rtmo = 0;
    logic [9:0]  m_d1 = '0;
    logic [2:0]  m_d2 = '0;
    logic [19:0] m_rdata = '0;
    int          m_done = 0, m_tmo = 0;

    // Fake core and stimulus knobs.
    int lat_cnt = 0;
    int core_lat = 4;
    int fix_data = -1;
    bit stray = 0;
    bit acc = 0;
    int pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic push;
        logic [13:0] h;
        core_out_valid = stray;
        core_out_data = 20'($urandom);
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                core_out_valid = 1'b1;
                if (fix_data >= 0) core_out_data = 20'(fix_data);
            end
        end
        stray = 0;
        push = req_valid && (m_q.size() < DEPTH);
        acc = push && rst_n;
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_phase = 0; m_cnt = 0; m_civ = 0; m_mode = 0; m_d1 = '0; m_d2 = '0;
            m_rv = 0; m_rmode = 0; m_rdata = '0; m_rtmo = 0;
            m_done = 0; m_tmo = 0; lat_cnt = 0;
        end else begin
            case (m_phase)
                0: if (m_q.size() > 0) begin
                    h = m_q.pop_front();
                    {m_mode, m_d1, m_d2} = h;
                    m_civ = 1; m_phase = 1;
                end
                1: begin m_civ = 0; m_cnt = 0; m_phase = 2; end
                2: if (core_out_valid) begin
                    m_rv = 1; m_rdata = core_out_data; m_rmode = m_mode; m_rtmo = 0; m_phase = 3;
                end else if (m_cnt == TIMEOUT) begin
                    m_rv = 1; m_rdata = '0; m_rmode = m_mode; m_rtmo = 1; m_phase = 3;
                end else begin
                    m_cnt++;
                end
                3: if (rsp_ready) begin
                    if (m_rtmo) m_tmo = (m_tmo < 255) ? m_tmo + 1 : m_tmo;
                    else m_done = (m_done < 65535) ? m_done + 1 : m_done;
                    m_rv = 0; m_phase = 0;
                end
                default: m_phase = 0;
            endcase
            if (push) m_q.push_back({req_mode, req_data_1, req_data_2});
            if (m_civ) begin
                pulses++;
                if (core_lat > 0) lat_cnt = core_lat;
            end
        end
        #1;
        chk("core_in_valid", 32'(core_in_valid), 32'(m_civ));
        chk("core_in_mode", 32'(core_in_mode), 32'(m_mode));
        chk("core_in_data_1", 32'(core_in_data_1), 32'(m_d1));
        chk("core_in_data_2", 32'(core_in_data_2), 32'(m_d2));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_mode", 32'(rsp_mode), 32'(m_rmode));
        chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(m_rtmo));
        chk("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(m_phase != 0 || m_q.size() != 0));
`ifdef SCHED_STATS_EN
        chk("stat_done", 32'(stat_done), 32'(m_done));
        chk("stat_tmo", 32'(stat_tmo), 32'(m_tmo));
`endif
    endtask

    task automatic send(input logic m, input logic [9:0] a, input logic [2:0] b);
        req_valid = 1'b1; req_mode = m; req_data_1 = a; req_data_2 = b;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_stuck", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (m_phase == 0 && m_q.size() == 0) break;
            tick();
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 200; i++) begin
            if (m_phase == p) break;
            tick();
        end
        chk("wait_phase", 32'(m_phase), 32'(p));
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single division, core answers 5 cycles after issue
        core_lat = 5; fix_data = 'h000E4; pulses = 0; rsp_ready = 1'b1;
        send(1'b0, 10'd100, 3'd7);
        drain();
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_rsp_data", 32'(rsp_data), 32'h000E4);
        chk("t1_rsp_mode", 32'(rsp_mode), 32'd0);
        chk("t1_rsp_tmo", 32'(rsp_timeout), 32'd0);
        fix_data = -1;

        // Five back-to-back requests with a slow core
        core_lat = 20; pulses = 0;
        for (int i = 0; i < 5; i++) send(1'(i), 10'(i * 37 + 1), 3'(i));
        chk("t2_full", 32'(req_ready), 32'd0);
        drain();
        chk("t2_pulses", 32'(pulses), 32'd5);

        // Root request, core never answers, then a normal one
        core_lat = 0;
        send(1'b1, 10'd513, 3'd2);
        drain();
        chk("t3_tmo", 32'(rsp_timeout), 32'd1);
        chk("t3_data", 32'(rsp_data), 32'd0);
        chk("t3_mode", 32'(rsp_mode), 32'd1);
        core_lat = 3;
        send(1'b0, 10'd9, 3'd3);
        drain();
        chk("t3_next_tmo", 32'(rsp_timeout), 32'd0);

        // Consumer back-pressure for 10 cycles during RESP
        rsp_ready = 1'b0; pulses = 0;
        send(1'b1, 10'd44, 3'd1);
        send(1'b0, 10'd45, 3'd5);
        wait_phase(3);
        for (int i = 0; i < 10; i++) tick();
        chk("t4_pulses", 32'(pulses), 32'd1);
        drain();
        chk("t4_pulses_end", 32'(pulses), 32'd2);

        // Alternating modes, stray core strobes while idle
        for (int i = 0; i < 6; i++) begin
            core_lat = 2 + i;
            send(1'(i), 10'($urandom), 3'($urandom));
            drain();
            chk("t5_mode", 32'(rsp_mode), 32'(i % 2));
            stray = 1;
            tick();
            chk("t5_stray", 32'(rsp_valid), 32'd0);
        end

        // Reset in WAIT with two requests queued
        core_lat = 0; rsp_ready = 1'b1;
        send(1'b1, 10'd1, 3'd1);
        send(1'b0, 10'd2, 3'd2);
        send(1'b1, 10'd3, 3'd3);
        wait_phase(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_mode = 1'($urandom);
            req_data_1 = 10'($urandom);
            req_data_2 = 3'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            core_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 12));
            stray = ($urandom_range(0, 19) == 0);
            tick();
        end
        req_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
